// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter in front of a single-ported data memory. A transaction takes
// two cycles: the request is arbitrated in IDLE, and the memory access happens
// in GRANT. The memory sees registered address, write data and strobes. It
// returns read data combinationally, and that data is captured at the edge
// that ends GRANT.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin arbitration with a last-grant
//                                pointer (reset value: port 1, so port 0 wins
//                                the first conflict).
//                   undefined -> fixed priority; port 0 wins every conflict
//                                and there is no pointer.
//
// Ports:
//   clk                      clock, rising edge
//   rst_n                    asynchronous active-low reset
//   req0/req1                request per port
//   we0/we1                  1 = write, 0 = read (stable while req is high)
//   addr0/addr1              word address (stable while req is high)
//   wdata0/wdata1            write data (stable while req is high)
//   ack0/ack1                one-cycle grant pulse (the GRANT cycle)
//   err0/err1                out-of-range flag, pulses together with ack
//   rvalid0/rvalid1          one-cycle read-data-valid pulse
//   rdata0/rdata1            read data, held until the port's next read
//   mem_addr/mem_wdata       registered address / write data to the memory
//   mem_write/mem_read       registered strobes to the memory
//   mem_rdata                combinational read data from the memory
//   busy                     high while the FSM is in GRANT
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int DEPTH_BITS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              err0,
   output logic              err1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Requester inputs gathered into per-port vectors so that the winner can
   // be selected by index.
   logic [1:0]             req_v;
   logic [1:0]             we_v;
   logic [1:0][ADDR_W-1:0] addr_v;
   logic [1:0][DATA_W-1:0] wdata_v;
   logic [1:0]             oor_v;

   assign req_v   = {req1, req0};
   assign we_v    = {we1, we0};
   assign addr_v  = {addr1, addr0};
   assign wdata_v = {wdata1, wdata0};

   // An address is out of range when any bit above the in-range field is set.
   // If the in-range field spans the whole address, nothing can be out of
   // range.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_range
         if (DEPTH_BITS < ADDR_W) begin : g_check
            assign oor_v[gi] = |addr_v[gi][ADDR_W-1:DEPTH_BITS];
         end else begin : g_full
            assign oor_v[gi] = 1'b0;
         end
      end
   endgenerate

   // State and registered outputs.
   state_t                 state_q,     state_d;
   logic [ADDR_W-1:0]      mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
   logic                   mem_write_q, mem_write_d;
   logic                   mem_read_q,  mem_read_d;
   logic [1:0]             ack_q,       ack_d;
   logic [1:0]             err_q,       err_d;
   logic [1:0]             rvalid_q,    rvalid_d;
   logic [1:0][DATA_W-1:0] rdata_q,     rdata_d;

   // Context of the transaction in GRANT. It is needed at the edge that ends
   // GRANT to steer the read data and rvalid back to the winning port.
   logic                   gnt_port_q,  gnt_port_d;
   logic                   gnt_rd_q,    gnt_rd_d;
   logic                   gnt_oor_q,   gnt_oor_d;

   // Winner of the arbitration in the current cycle. It is only used when the
   // FSM is in IDLE and at least one request is high.
   logic                   win;

`ifdef DMEM_ARB_RR_EN
   // Last-grant pointer. On a conflict the port that was not granted last
   // wins. The pointer moves on every grant, including grants with no
   // conflict.
   logic last_q, last_d;

   always_comb begin
      if (req_v == 2'b11) begin
         win = ~last_q;
      end else begin
         win = ~req_v[0];
      end
   end

   always_comb begin
      last_d = last_q;
      if ((state_q == IDLE) && (|req_v)) begin
         last_d = win;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Fixed priority: port 0 wins whenever it is requesting.
   always_comb begin
      win = ~req_v[0];
   end
`endif

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;
      ack_d       = 2'b00;
      err_d       = 2'b00;
      rvalid_d    = 2'b00;
      rdata_d     = rdata_q;
      gnt_port_d  = gnt_port_q;
      gnt_rd_d    = gnt_rd_q;
      gnt_oor_d   = gnt_oor_q;

      case (state_q)
         IDLE: begin
            if (|req_v) begin
               state_d     = GRANT;
               // Address and data are registered even for an out-of-range
               // access. The strobes are suppressed in that case, so the
               // memory never acts on them.
               mem_addr_d  = addr_v[win];
               mem_wdata_d = wdata_v[win];
               mem_write_d = we_v[win] & ~oor_v[win];
               mem_read_d  = ~we_v[win] & ~oor_v[win];
               ack_d[win]  = 1'b1;
               err_d[win]  = oor_v[win];
               gnt_port_d  = win;
               gnt_rd_d    = ~we_v[win];
               gnt_oor_d   = oor_v[win];
            end
         end

         GRANT: begin
            // The strobes default to 0, so they clear at this edge. The
            // memory commits a write at the same edge.
            state_d = IDLE;
            if (gnt_rd_q) begin
               rvalid_d[gnt_port_q] = 1'b1;
               rdata_d[gnt_port_q]  = gnt_oor_q ? '0 : mem_rdata;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         ack_q       <= 2'b00;
         err_q       <= 2'b00;
         rvalid_q    <= 2'b00;
         rdata_q     <= '0;
         gnt_port_q  <= 1'b0;
         gnt_rd_q    <= 1'b0;
         gnt_oor_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_write_q <= mem_write_d;
         mem_read_q  <= mem_read_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         gnt_port_q  <= gnt_port_d;
         gnt_rd_q    <= gnt_rd_d;
         gnt_oor_q   <= gnt_oor_d;
      end
   end

   assign ack0      = ack_q[0];
   assign ack1      = ack_q[1];
   assign err0      = err_q[0];
   assign err1      = err_q[1];
   assign rvalid0   = rvalid_q[0];
   assign rvalid1   = rvalid_q[1];
   assign rdata0    = rdata_q[0];
   assign rdata1    = rdata_q[1];
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_write = mem_write_q;
   assign mem_read  = mem_read_q;
   assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Scoreboard bench for dmem_arbiter. The driver keeps one pending transaction
// per port. For each arbitration slot it decides the winner from the policy
// rules and predicts the ack, err, strobe and address response and any read
// data from a word-array model of memory. Each prediction goes into a queue.
// A separate monitor pops and compares each entry when the DUT shows ack or
// rvalid. The memory attached to the DUT is a separate array that is written
// only through the DUT's mem_write strobe.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int DB = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, err0, err1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_write, mem_read;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_BITS(DB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .req1      (req1),
      .we0       (we0),
      .we1       (we1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .ack0      (ack0),
      .ack1      (ack1),
      .err0      (err0),
      .err1      (err1),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .rdata0    (rdata0),
      .rdata1    (rdata1),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_write (mem_write),
      .mem_read  (mem_read),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // Memory attached to the DUT: synchronous write, combinational read.
   logic [DW-1:0] env_mem [256];
   always @(posedge clk) begin
      if (mem_write) env_mem[mem_addr[7:0]] <= mem_wdata;
   end
   assign mem_rdata = env_mem[mem_addr[7:0]];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            port;
      bit            err;
      bit            wr;
      bit            rd;
      logic [AW-1:0] addr;
      int            cyc;
   } ack_exp_t;

   typedef struct {
      int            port;
      logic [DW-1:0] data;
      int            cyc;
   } rv_exp_t;

   ack_exp_t ack_sb[$];
   rv_exp_t  rv_sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model state.
   logic [DW-1:0] ref_mem [256];
   int            last_grant;
   bit            pend   [2];
   bit            pwe    [2];
   logic [AW-1:0] paddr  [2];
   logic [DW-1:0] pwdata [2];

   function automatic int pick_winner();
      if (pend[0] && pend[1]) begin
`ifdef DMEM_ARB_RR_EN
         return (last_grant == 0) ? 1 : 0;
`else
         return 0;
`endif
      end
      return pend[0] ? 0 : 1;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      int k;
      k = $urandom_range(0, 19);
      if (k < 17)      return AW'($urandom_range(0, 15));
      else if (k < 19) return AW'(16'h0100 | $urandom_range(0, 15));
      else             return AW'(16'h8000 | $urandom_range(0, 15));
   endfunction

   task automatic new_txn(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend[p]   = 1'b1;
      pwe[p]    = we;
      paddr[p]  = a;
      pwdata[p] = d;
   endtask

   task automatic drive();
      req0   = pend[0];
      we0    = pwe[0];
      addr0  = paddr[0];
      wdata0 = pwdata[0];
      req1   = pend[1];
      we1    = pwe[1];
      addr1  = paddr[1];
      wdata1 = pwdata[1];
   endtask

   // One arbitration slot. The task is entered just after a rising edge with
   // the DUT in IDLE. It predicts the outcome, drives the requests, and
   // returns just after the edge that ends GRANT.
   task automatic do_slot();
      int       w;
      bit       oor;
      ack_exp_t a;
      rv_exp_t  r;
      if (!pend[0] && !pend[1]) begin
         drive();
         @(posedge clk);
         #1;
         return;
      end
      w      = pick_winner();
      oor    = (paddr[w] >> DB) != 0;
      a.port = w;
      a.err  = oor;
      a.wr   = pwe[w] && !oor;
      a.rd   = !pwe[w] && !oor;
      a.addr = paddr[w];
      a.cyc  = cyc + 1;
      ack_sb.push_back(a);
      if (!pwe[w]) begin
         r.port = w;
         r.data = oor ? '0 : ref_mem[paddr[w][7:0]];
         r.cyc  = cyc + 2;
         rv_sb.push_back(r);
      end else if (!oor) begin
         ref_mem[paddr[w][7:0]] = pwdata[w];
      end
      last_grant = w;
      drive();
      @(posedge clk);
      @(posedge clk);
      #1;
      pend[w] = 1'b0;
   endtask

   // Monitor: compares the DUT response against the scoreboard queues.
   always @(negedge clk) begin : monitor
      ack_exp_t a;
      rv_exp_t  r;
      if (rst_n) begin
         chk("busy_vs_ack", {31'd0, busy}, {31'd0, ack0 | ack1});
         if (ack0 | ack1) begin
            if (ack_sb.size() == 0) begin
               chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
               a = ack_sb.pop_front();
               chk("ack_cycle", cyc, a.cyc);
               chk("ack_port", {30'd0, ack1, ack0}, (a.port == 0) ? 32'd1 : 32'd2);
               chk("err", {30'd0, err1, err0}, !a.err ? 32'd0 : ((a.port == 0) ? 32'd1 : 32'd2));
               chk("mem_write", {31'd0, mem_write}, {31'd0, a.wr});
               chk("mem_read", {31'd0, mem_read}, {31'd0, a.rd});
               chk("mem_addr", {16'd0, mem_addr}, {16'd0, a.addr});
            end
         end else begin
            chk("idle_strobes", {28'd0, mem_write, mem_read, err1, err0}, 32'd0);
         end
         if (rvalid0 | rvalid1) begin
            if (rv_sb.size() == 0) begin
               chk("unexpected_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
            end else begin
               r = rv_sb.pop_front();
               chk("rvalid_cycle", cyc, r.cyc);
               chk("rvalid_port", {30'd0, rvalid1, rvalid0}, (r.port == 0) ? 32'd1 : 32'd2);
               chk("rdata", {16'd0, (r.port == 0) ? rdata0 : rdata1}, {16'd0, r.data});
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         env_mem[i] = '0;
         ref_mem[i] = '0;
      end
      for (int p = 0; p < 2; p++) begin
         pend[p]   = 1'b0;
         pwe[p]    = 1'b0;
         paddr[p]  = '0;
         pwdata[p] = '0;
      end
      last_grant = 1;
      drive();
      rst_n = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_flags", {23'd0, ack1, ack0, err1, err0, rvalid1, rvalid0, busy, mem_write, mem_read}, 32'd0);
      chk("reset_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("reset_mem_wdata", {16'd0, mem_wdata}, 32'd0);
      chk("reset_rdata", {rdata1, rdata0}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Both ports requesting from reset, held with a fresh read each time.
      for (int i = 0; i < 4; i++) begin
         if (!pend[0]) new_txn(0, 1'b0, AW'(16'h0020 + i), '0);
         if (!pend[1]) new_txn(1, 1'b0, AW'(16'h0030 + i), '0);
         do_slot();
      end
      while (pend[0] || pend[1]) do_slot();

      // Write then read back.
      new_txn(0, 1'b1, 16'h0010, 16'hBEEF);
      do_slot();
      new_txn(0, 1'b0, 16'h0010, '0);
      do_slot();
      chk("wr_rd_rdata0", {16'd0, rdata0}, 32'h0000BEEF);

      // Out-of-range read, then an out-of-range write whose low bits alias
      // 0x0010. The read-back of 0x0010 must still return 0xBEEF.
      new_txn(1, 1'b0, 16'h0100, '0);
      do_slot();
      chk("oor_rdata1", {16'd0, rdata1}, 32'd0);
      new_txn(0, 1'b1, 16'h0110, 16'h5555);
      do_slot();
      new_txn(0, 1'b0, 16'h0010, '0);
      do_slot();

      // Back-to-back reads on port 1.
      for (int i = 0; i < 3; i++) begin
         new_txn(1, 1'b0, AW'(16'h0040 + i), '0);
         do_slot();
      end

      // Reset while in GRANT aborts the write.
      new_txn(0, 1'b1, 16'h0005, 16'h1234);
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_ack0", {31'd0, ack0}, 32'd0);
      chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      pend[0] = 1'b0;
      drive();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      last_grant = 1;
      new_txn(0, 1'b0, 16'h0005, '0);
      do_slot();

      // Randomized traffic.
      for (int it = 0; it < 400; it++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && ($urandom_range(0, 9) < 6)) begin
               new_txn(p, 1'($urandom_range(0, 1)), rand_addr(), DW'($urandom));
            end
         end
         do_slot();
      end
      while (pend[0] || pend[1]) do_slot();
      drive();
      repeat (4) @(posedge clk);
      #1;
      chk("ack_queue_drained", ack_sb.size(), 32'd0);
      chk("rvalid_queue_drained", rv_sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
